hp_bar_renderer: RTL and testbench



---
 rtl/pokemon_pkg.sv | 32 +++
 rtl/bar_pixel_gen.sv | 70 +++++++
 rtl/hp_bar_renderer.sv | 203 ++++++++++++++++++++
 tb/tb_hp_bar_renderer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pokemon_pkg.sv
// -----------------------------------------------------------------------------
// pokemon_pkg
// Shared constants and types for the Pokemon battle display blocks.
//   - Framebuffer geometry (160x120, 6-bit RRGGBB colour)
//   - Colour constants used by the HP bar renderer
//   - Renderer state encoding
//   - clamp_hp(): saturate an HP value at a maximum
// -----------------------------------------------------------------------------
package pokemon_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [5:0] COL_GREEN  = 6'b001100;
    localparam logic [5:0] COL_YELLOW = 6'b111100;
    localparam logic [5:0] COL_RED    = 6'b110000;
    localparam logic [5:0] COL_GREY   = 6'b010101;
    localparam logic [5:0] COL_WHITE  = 6'b111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW1 = 2'd1,
        DRAW2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [6:0] clamp_hp(input logic [6:0] hp,
                                            input logic [6:0] hp_max);
        return (hp > hp_max) ? hp_max : hp;
    endfunction

endpackage

// File: rtl/bar_pixel_gen.sv
// -----------------------------------------------------------------------------
// bar_pixel_gen
// Purely combinational pixel generator for one HP bar.
//   col    in  7  column counter within the bar region
//   row    in  4  row counter within the bar region
//   hp     in  7  latched (clamped) HP of the bar being drawn
//   org_x  in  8  left column of the bar region
//   org_y  in  7  top row of the bar region
//   x      out 8  framebuffer column  (org_x + col)
//   y      out 7  framebuffer row     (org_y + row)
//   colour out 6  fill / grey / (border) colour
// Macro HP_BAR_BORDER_EN: region includes a 1-pixel white frame; the fill
// column is then col-1.
// -----------------------------------------------------------------------------
module bar_pixel_gen
    import pokemon_pkg::*;
#(
    parameter int BAR_W  = 40,
`ifdef HP_BAR_BORDER_EN
    parameter int BAR_H  = 4,
`endif
    parameter int HP_MAX = 100
) (
    input  logic [6:0] col,
    input  logic [3:0] row,
    input  logic [6:0] hp,
    input  logic [7:0] org_x,
    input  logic [6:0] org_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [5:0] colour
);

    logic [6:0]  fill_c;
    logic [13:0] lhs;
    logic [13:0] rhs;
    logic        filled;
    logic [5:0]  fill_colour;

    assign x = org_x + 8'(col);
    assign y = org_y + 7'(row);

    always_comb begin
        if (hp > 7'(HP_MAX / 2))
            fill_colour = COL_GREEN;
        else if (hp > 7'(HP_MAX / 4))
            fill_colour = COL_YELLOW;
        else
            fill_colour = COL_RED;

`ifdef HP_BAR_BORDER_EN
        fill_c = col - 7'd1;
`else
        fill_c = col;
`endif
        // c*HP_MAX < hp*BAR_W  <=>  c < hp*BAR_W/HP_MAX, without a divider
        lhs    = 14'(fill_c) * 14'(HP_MAX);
        rhs    = 14'(hp) * 14'(BAR_W);
        filled = (lhs < rhs);

        colour = filled ? fill_colour : COL_GREY;

`ifdef HP_BAR_BORDER_EN
        if (col == 7'd0 || col == 7'(BAR_W + 1) ||
            row == 4'd0 || row == 4'(BAR_H + 1))
            colour = COL_WHITE;
`endif
    end

endmodule

// File: rtl/hp_bar_renderer.sv
// -----------------------------------------------------------------------------
// hp_bar_renderer
// Draws both HP bars into the 160x120 framebuffer, one pixel per clock.
//   clock  in  1  system clock
//   reset  in  1  synchronous, active-high reset
//   start  in  1  one-cycle redraw request (ignored while busy / done)
//   hp1    in  7  player-1 HP, sampled when start is accepted
//   hp2    in  7  player-2 HP, sampled when start is accepted
//   busy   out 1  high while drawing
//   done   out 1  one-cycle pulse after the last pixel
//   x      out 8  framebuffer column
//   y      out 7  framebuffer row
//   colour out 6  RRGGBB
//   plot   out 1  write strobe to vga_adapter
// Macro HP_BAR_BORDER_EN: each bar gets a 1-pixel white frame.
//
// state | meaning
// IDLE  | waiting for start
// DRAW1 | emitting bar-1 pixels, row-major
// DRAW2 | emitting bar-2 pixels, row-major
// DONE  | one cycle: done=1, busy=0
// -----------------------------------------------------------------------------
module hp_bar_renderer
    import pokemon_pkg::*;
#(
    parameter int BAR_W  = 40,
    parameter int BAR_H  = 4,
    parameter int HP_MAX = 100,
    parameter int P1_X   = 8,
    parameter int P1_Y   = 100,
    parameter int P2_X   = 112,
    parameter int P2_Y   = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] hp1,
    input  logic [6:0] hp2,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [5:0] colour,
    output logic       plot
);

`ifdef HP_BAR_BORDER_EN
    localparam int REG_W = BAR_W + 2;
    localparam int REG_H = BAR_H + 2;
    localparam int OFS   = 1;
`else
    localparam int REG_W = BAR_W;
    localparam int REG_H = BAR_H;
    localparam int OFS   = 0;
`endif

    localparam logic [6:0] COL_LAST = 7'(REG_W - 1);
    localparam logic [3:0] ROW_LAST = 4'(REG_H - 1);
    localparam logic [7:0] B1_X     = 8'(P1_X - OFS);
    localparam logic [6:0] B1_Y     = 7'(P1_Y - OFS);
    localparam logic [7:0] B2_X     = 8'(P2_X - OFS);
    localparam logic [6:0] B2_Y     = 7'(P2_Y - OFS);

    state_t     state, state_nx;
    logic [6:0] col_cnt;
    logic [3:0] row_cnt;
    logic [6:0] hp1_l, hp2_l;
    logic       last_pix;

    logic [6:0] hp_sel;
    logic [7:0] org_x_sel;
    logic [6:0] org_y_sel;
    logic [7:0] gen_x;
    logic [6:0] gen_y;
    logic [5:0] gen_colour;

    logic       busy_d, done_d, plot_d;
    logic [7:0] x_d;
    logic [6:0] y_d;
    logic [5:0] colour_d;

    assign last_pix = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)    state_nx = DRAW1;
            DRAW1:   if (last_pix) state_nx = DRAW2;
            DRAW2:   if (last_pix) state_nx = DONE;
            DONE:                  state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    // counters and HP latches
    always_ff @(posedge clock) begin
        if (reset) begin
            col_cnt <= '0;
            row_cnt <= '0;
            hp1_l   <= '0;
            hp2_l   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    col_cnt <= '0;
                    row_cnt <= '0;
                    hp1_l   <= clamp_hp(hp1, 7'(HP_MAX));
                    hp2_l   <= clamp_hp(hp2, 7'(HP_MAX));
                end
                DRAW1, DRAW2: begin
                    // wrapping on the last pixel also clears for the next bar
                    if (col_cnt == COL_LAST) begin
                        col_cnt <= '0;
                        row_cnt <= (row_cnt == ROW_LAST) ? 4'd0 : row_cnt + 4'd1;
                    end else begin
                        col_cnt <= col_cnt + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // single generator shared by both bars
    always_comb begin
        if (state == DRAW2) begin
            hp_sel    = hp2_l;
            org_x_sel = B2_X;
            org_y_sel = B2_Y;
        end else begin
            hp_sel    = hp1_l;
            org_x_sel = B1_X;
            org_y_sel = B1_Y;
        end
    end

    bar_pixel_gen #(
        .BAR_W  (BAR_W),
`ifdef HP_BAR_BORDER_EN
        .BAR_H  (BAR_H),
`endif
        .HP_MAX (HP_MAX)
    ) u_gen (
        .col    (col_cnt),
        .row    (row_cnt),
        .hp     (hp_sel),
        .org_x  (org_x_sel),
        .org_y  (org_y_sel),
        .x      (gen_x),
        .y      (gen_y),
        .colour (gen_colour)
    );

    // output logic (next values of the output registers)
    always_comb begin
        busy_d   = 1'b0;
        done_d   = 1'b0;
        plot_d   = 1'b0;
        x_d      = x;
        y_d      = y;
        colour_d = colour;
        case (state)
            IDLE:    busy_d = start;
            DRAW1, DRAW2: begin
                busy_d   = 1'b1;
                plot_d   = 1'b1;
                x_d      = gen_x;
                y_d      = gen_y;
                colour_d = gen_colour;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            busy   <= busy_d;
            done   <= done_d;
            plot   <= plot_d;
            x      <= x_d;
            y      <= y_d;
            colour <= colour_d;
        end
    end

endmodule

// File: tb/tb_hp_bar_renderer.sv
// -----------------------------------------------------------------------------
// tb_hp_bar_renderer
// Self-checking bench for hp_bar_renderer with default parameters.
// Expected pixel streams are built from hand-computed fill counts and colours
// per test vector and queued; DUT pixels are popped and compared as they appear.
// -----------------------------------------------------------------------------
module tb_hp_bar_renderer;

    localparam logic [5:0] GRN = 6'b001100;
    localparam logic [5:0] YEL = 6'b111100;
    localparam logic [5:0] RD  = 6'b110000;
    localparam logic [5:0] GRY = 6'b010101;
    localparam logic [5:0] WHT = 6'b111111;

`ifdef HP_BAR_BORDER_EN
    localparam int NPIX = 504;
`else
    localparam int NPIX = 320;
`endif
    localparam int DONE_CYC = NPIX + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] hp1 = '0;
    logic [6:0] hp2 = '0;
    logic       busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [5:0] colour;

    hp_bar_renderer dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .hp1    (hp1),
        .hp2    (hp2),
        .busy   (busy),
        .done   (done),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [5:0] c;
    } pix_t;

    typedef struct {
        logic [6:0] hp1;
        logic [6:0] hp2;
        int         nf1;
        logic [5:0] c1;
        int         nf2;
        logic [5:0] c2;
    } case_t;

    pix_t  exp_q[$];
    case_t tbl[6];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_bar(input int ox, input int oy, input int nf, input logic [5:0] fc);
        pix_t p;
`ifdef HP_BAR_BORDER_EN
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 42; c++) begin
                p.x = 8'(ox - 1 + c);
                p.y = 7'(oy - 1 + r);
                if (r == 0 || r == 5 || c == 0 || c == 41) p.c = WHT;
                else p.c = (c - 1 < nf) ? fc : GRY;
                exp_q.push_back(p);
            end
`else
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 40; c++) begin
                p.x = 8'(ox + c);
                p.y = 7'(oy + r);
                p.c = (c < nf) ? fc : GRY;
                exp_q.push_back(p);
            end
`endif
    endtask

    // disturb_at / reset_at: cycle (relative to start edge 0) at whose
    // sampling point a stray start or a reset is driven; -1 for none.
    task automatic run(input case_t tc, input int disturb_at, input int reset_at);
        pix_t e;
        int   ndone;
        int   done_at;
        int   exp_on;
        exp_q.delete();
        push_bar(8, 100, tc.nf1, tc.c1);
        push_bar(112, 10, tc.nf2, tc.c2);
        @(negedge clock);
        hp1   = tc.hp1;
        hp2   = tc.hp2;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        hp1   = 7'($urandom);
        hp2   = 7'($urandom);
        check("cycle0_busy", int'(busy), 1);
        check("cycle0_plot", int'(plot), 0);
        ndone   = 0;
        done_at = -1;
        for (int k = 1; k <= DONE_CYC + 10; k++) begin
            if (k - 1 == disturb_at) begin
                start = 1'b1;
                hp1   = 7'd10;
                hp2   = 7'd90;
            end
            if (k - 1 == disturb_at + 1) start = 1'b0;
            if (k - 1 == reset_at) reset = 1'b1;
            if (k - 1 == reset_at + 1) reset = 1'b0;
            @(negedge clock);
            if (done) begin
                ndone++;
                done_at = k;
            end
            if (reset_at >= 0 && k > reset_at) begin
                check("after_reset_plot_busy_done", int'({plot, busy, done}), 0);
            end else begin
                exp_on = (k <= NPIX) ? 1 : 0;
                check("plot", int'(plot), exp_on);
                check("busy", int'(busy), exp_on);
                check("done", int'(done), (k == DONE_CYC) ? 1 : 0);
                if (plot && exp_on == 1) begin
                    if (exp_q.size() == 0) begin
                        check("queue_underflow", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("x", int'(x), int'(e.x));
                        check("y", int'(y), int'(e.y));
                        check("colour", int'(colour), int'(e.c));
                    end
                end
            end
        end
        if (reset_at < 0) begin
            check("pixels_left", exp_q.size(), 0);
            check("done_count", ndone, 1);
            check("done_cycle", done_at, DONE_CYC);
        end else begin
            check("done_count_after_reset", ndone, 0);
        end
    endtask

    initial begin
        // hp1, hp2, filled cols bar1, colour bar1, filled cols bar2, colour bar2
        tbl[0] = '{7'd100, 7'd0,   40, GRN, 0,  GRY};
        tbl[1] = '{7'd50,  7'd25,  20, YEL, 10, RD };
        tbl[2] = '{7'd51,  7'd127, 21, GRN, 40, GRN};
        tbl[3] = '{7'd1,   7'd75,  1,  RD,  30, GRN};
        tbl[4] = '{7'd26,  7'd24,  11, YEL, 10, RD };
        tbl[5] = '{7'd99,  7'd2,   40, GRN, 1,  RD };

        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_busy",   int'(busy),   0);
        check("reset_done",   int'(done),   0);
        check("reset_plot",   int'(plot),   0);
        check("reset_x",      int'(x),      0);
        check("reset_y",      int'(y),      0);
        check("reset_colour", int'(colour), 0);

        for (int i = 0; i < 6; i++)
            run(tbl[i], -1, -1);

        // stray start during the draw must not disturb anything
        run(tbl[1], 50, -1);
        // reset mid-draw, then a clean run
        run(tbl[0], -1, 200);
        run(tbl[2], -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
